coin_feeder: RTL

Customer-side driver for the vending controller's coin interface. It accepts a purchase plan, issues one-cycle fifty/dollar/cancel pulses only while the controller asserts insert_coin, then waits for dispense or money_return and reports the outcome. It is used as the stimulus end of the vending protocol on the board and in system benches, and it keeps saturating outcome counters.

---
 rtl/coin_feeder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/coin_feeder.sv
// coin_feeder: customer-side coin driver for the vending controller; issues plan-driven coin pulses, reports outcome.
// Optional COIN_FEEDER_TOCNT_EN adds a saturating timeout counter output to_cnt.
module coin_feeder #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       plan,
  input  logic             insert_coin,
  input  logic             dispense,
  input  logic             money_return,
  output logic             fifty,
  output logic             dollar,
  output logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [1:0]       result,
  output logic [CNT_W-1:0] vend_cnt,
`ifdef COIN_FEEDER_TOCNT_EN
  output logic [CNT_W-1:0] to_cnt,
`endif
  output logic [CNT_W-1:0] ret_cnt
);

  typedef enum logic [2:0] {
    IDLE, WAIT_RDY, COIN1, GAP, COIN2, WAIT_RSP, DONE
  } state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t     state;
  logic [1:0] plan_q;
  logic [7:0] timer;
  logic [7:0] timer_nxt;

  assign timer_nxt = timer + 8'd1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      plan_q   <= 2'b00;
      timer    <= 8'd0;
      fifty    <= 1'b0;
      dollar   <= 1'b0;
      cancel   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 2'b00;
      vend_cnt <= '0;
      ret_cnt  <= '0;
`ifdef COIN_FEEDER_TOCNT_EN
      to_cnt   <= '0;
`endif
    end else begin
      // Pulses and done are single-cycle: cleared by default, set only on entry to their state.
      fifty  <= 1'b0;
      dollar <= 1'b0;
      cancel <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            plan_q <= plan;
            timer  <= 8'd0;
            result <= 2'b00;
            busy   <= 1'b1;
            state  <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (insert_coin) begin
            if (plan_q == 2'b01) dollar <= 1'b1;
            else                 fifty  <= 1'b1;
            state <= COIN1;
          end else begin
            timer <= timer_nxt;
            if (timer_nxt == TO_LIMIT) begin
              result <= 2'b11;
              done   <= 1'b1;
              state  <= DONE;
`ifdef COIN_FEEDER_TOCNT_EN
              to_cnt <= sat_inc(to_cnt);
`endif
            end
          end
        end
        COIN1: state <= GAP;
        GAP: begin
          timer <= 8'd0;
          if (plan_q == 2'b01) begin
            state <= WAIT_RSP;
          end else begin
            case (plan_q)
              2'b00:   fifty  <= 1'b1;
              2'b10:   cancel <= 1'b1;
              default: dollar <= 1'b1;
            endcase
            state <= COIN2;
          end
        end
        COIN2: state <= WAIT_RSP;
        WAIT_RSP: begin
          // money_return may be a single-cycle pulse, so responses are sampled every cycle here.
          if (dispense) begin
            result   <= 2'b01;
            vend_cnt <= sat_inc(vend_cnt);
            done     <= 1'b1;
            state    <= DONE;
          end else if (money_return) begin
            result  <= 2'b10;
            ret_cnt <= sat_inc(ret_cnt);
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            timer <= timer_nxt;
            if (timer_nxt == TO_LIMIT) begin
              result <= 2'b11;
              done   <= 1'b1;
              state  <= DONE;
`ifdef COIN_FEEDER_TOCNT_EN
              to_cnt <= sat_inc(to_cnt);
`endif
            end
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
